// File: rtl/ahb_gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO peripheral: register offsets,
// register index values (HADDR[4:2]), AHB transfer encodings and STATUS bits.
package ahb_gpio_pkg;

    // Byte offsets of the register map
    localparam logic [7:0] OFF_DATA     = 8'h00;
    localparam logic [7:0] OFF_DIR      = 8'h04;
    localparam logic [7:0] OFF_STATUS   = 8'h08;
    localparam logic [7:0] OFF_IRQ_MASK = 8'h0C;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h10;
    localparam logic [7:0] OFF_IRQ_RISE = 8'h14;

    // Word index as decoded from HADDR[4:2]
    localparam logic [2:0] IDX_DATA     = OFF_DATA[4:2];
    localparam logic [2:0] IDX_DIR      = OFF_DIR[4:2];
    localparam logic [2:0] IDX_STATUS   = OFF_STATUS[4:2];
    localparam logic [2:0] IDX_IRQ_MASK = OFF_IRQ_MASK[4:2];
    localparam logic [2:0] IDX_IRQ_STAT = OFF_IRQ_STAT[4:2];
    localparam logic [2:0] IDX_IRQ_RISE = OFF_IRQ_RISE[4:2];

    // AHB-Lite HTRANS encodings
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // STATUS register: sticky input parity error flag
    localparam int STATUS_PERR_BIT = 0;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for asynchronous GPIO pins.
// Synchronous active-high reset clears every stage.
module gpio_sync
    import ahb_gpio_pkg::*;
#(
    parameter int W      = 17,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sync_q [STAGES];
    logic [W-1:0] sync_d [STAGES];

    // Shift chain: stage 0 samples the pins, each later stage copies its predecessor
    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Stage registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (rst) begin
                sync_q[i] <= '0;
            end else begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/ahb_gpio_param.sv
// AHB-Lite zero-wait-state GPIO peripheral with parity-protected pins,
// per-bit direction, and a sticky input parity error flag.
// Optional feature macro: GPIO_IRQ_EN adds edge interrupts (IRQ_MASK,
// IRQ_STAT, IRQ_RISE registers and the GPIOIRQ output).
module ahb_gpio_param
    import ahb_gpio_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    input  logic [DATA_W:0]   GPIOIN,
    input  logic              PARITYSEL,
    output logic [DATA_W:0]   GPIOOUT,
    output logic [DATA_W-1:0] GPIOOE,
`ifdef GPIO_IRQ_EN
    output logic              PARITYERR,
    output logic              GPIOIRQ
`else
    output logic              PARITYERR
`endif
);

    // Bus control captured in the address phase
    logic              dphase_q, dphase_d;
    logic              write_q,  write_d;
    logic [2:0]        addr_q,   addr_d;
    // Programmer-visible registers
    logic [DATA_W-1:0] out_q,    out_d;
    logic [DATA_W-1:0] dir_q,    dir_d;
    logic              status_q, status_d;

    logic              accept;
    logic              wr_en;
    logic [DATA_W:0]   in_s;
    logic              err_now;
    logic [DATA_W-1:0] drive;
    logic              unused_ok;

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign wr_en     = dphase_q & write_q;
    assign err_now   = (^in_s) != PARITYSEL;
    assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:DATA_W]};

    gpio_sync #(
        .W      (DATA_W + 1),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (HCLK),
        .rst  (HRESET),
        .din  (GPIOIN),
        .dout (in_s)
    );

`ifdef GPIO_IRQ_EN
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] rise_q, rise_d;
    logic [DATA_W-1:0] stat_q, stat_d;
    logic [DATA_W-1:0] in_p_q;
    logic              irq_q;
    logic [DATA_W-1:0] edge_hit;

    // Edge detect: rising-only where IRQ_RISE is set, otherwise any change
    assign edge_hit = (rise_q & in_s[DATA_W-1:0] & ~in_p_q)
                    | (~rise_q & (in_s[DATA_W-1:0] ^ in_p_q));

    // Interrupt register updates; a new masked edge wins over a same-cycle W1C
    always_comb begin
        mask_d = mask_q;
        rise_d = rise_q;
        stat_d = stat_q;
        if (wr_en && addr_q == IDX_IRQ_MASK) mask_d = HWDATA[DATA_W-1:0];
        if (wr_en && addr_q == IDX_IRQ_RISE) rise_d = HWDATA[DATA_W-1:0];
        if (wr_en && addr_q == IDX_IRQ_STAT) stat_d = stat_q & ~HWDATA[DATA_W-1:0];
        stat_d = stat_d | (edge_hit & mask_q);
    end

    // Interrupt state; GPIOIRQ is registered so it follows IRQ_STAT by one cycle
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            mask_q <= '0;
            rise_q <= '0;
            stat_q <= '0;
            in_p_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            rise_q <= rise_d;
            stat_q <= stat_d;
            in_p_q <= in_s[DATA_W-1:0];
            irq_q  <= |stat_q;
        end
    end

    assign GPIOIRQ = irq_q;
`endif

    // Address-phase capture; only NONSEQ/SEQ with HSEL and HREADY start a data phase
    always_comb begin
        dphase_d = accept;
        write_d  = accept ? HWRITE : write_q;
        addr_d   = accept ? HADDR[4:2] : addr_q;
    end

    // Core register writes; a parity error wins over a same-cycle STATUS clear
    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        status_d = status_q;
        if (wr_en && addr_q == IDX_DATA) out_d = HWDATA[DATA_W-1:0];
        if (wr_en && addr_q == IDX_DIR)  dir_d = HWDATA[DATA_W-1:0];
        if (wr_en && addr_q == IDX_STATUS && HWDATA[STATUS_PERR_BIT]) status_d = 1'b0;
        if (err_now) status_d = 1'b1;
    end

    // Bus control and core registers; reset also discards a pending data phase
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dphase_q <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            out_q    <= '0;
            dir_q    <= '0;
            status_q <= 1'b0;
        end else begin
            dphase_q <= dphase_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            out_q    <= out_d;
            dir_q    <= dir_d;
            status_q <= status_d;
        end
    end

    // Read mux, driven only during a read data phase; unmapped offsets read 0
    always_comb begin
        HRDATA = '0;
        if (dphase_q && !write_q) begin
            case (addr_q)
                IDX_DATA:     HRDATA[DATA_W-1:0] = in_s[DATA_W-1:0];
                IDX_DIR:      HRDATA[DATA_W-1:0] = dir_q;
                IDX_STATUS:   HRDATA[STATUS_PERR_BIT] = status_q;
`ifdef GPIO_IRQ_EN
                IDX_IRQ_MASK: HRDATA[DATA_W-1:0] = mask_q;
                IDX_IRQ_STAT: HRDATA[DATA_W-1:0] = stat_q;
                IDX_IRQ_RISE: HRDATA[DATA_W-1:0] = rise_q;
`endif
                default:      HRDATA = '0;
            endcase
        end
    end

    assign drive     = out_q & dir_q;
    assign GPIOOUT   = {(^drive) ^ PARITYSEL, drive};
    assign GPIOOE    = dir_q;
    assign PARITYERR = status_q;
    assign HREADYOUT = 1'b1;

endmodule
